// File: rtl/sprite_renderer.sv
// rtl/sprite_renderer.sv - scaled, animated, colour-keyed sprite pixel generator with a 3-stage ROM pipeline
// Optional horizontal mirror (flip port) built when SPRITE_FLIP_EN is defined.
module sprite_renderer #(
  parameter int SPR_W       = 64,
  parameter int SPR_H       = 64,
  parameter int FRAMES      = 4,
  parameter int SCALE       = 2,
  parameter int FRAME_TICKS = 8,
  parameter int KEY_INDEX   = 0,
  parameter int AW          = $clog2(FRAMES*SPR_W*SPR_H)
) (
  input  logic                        vga_clk,
  input  logic                        reset_n,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic                        blank,
  input  logic [9:0]                  pos_x,
  input  logic [9:0]                  pos_y,
  input  logic                        anim_en,
  input  logic                        anim_restart,
`ifdef SPRITE_FLIP_EN
  input  logic                        flip,
`endif
  output logic [AW-1:0]               rom_address,
  input  logic [3:0]                  rom_q,
  output logic [3:0]                  pix_index,
  output logic                        pix_opaque,
  output logic [$clog2(FRAMES)-1:0]   frame_idx
);

  localparam int FW = $clog2(FRAMES);
  localparam int UW = $clog2(SPR_W);
  localparam int VW = $clog2(SPR_H);
  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  logic [10:0]   x_end, y_end;
  logic [9:0]    dx, dy;
  logic          hit;
  logic [UW-1:0] u, u_eff;
  logic [VW-1:0] v;
  logic [AW-1:0] addr_next;
  logic          at_origin, at_origin_q, frame_start;
  logic [TW-1:0] tick;
  logic          hit_d1, blank_d1, hit_d2, blank_d2;
  logic [2:0]    vld;
  logic          opaque_next;

  // Box edges computed one bit wider so a sprite near the right/bottom clips instead of wrapping.
  assign x_end = {1'b0, pos_x} + 11'(SPR_W*SCALE);
  assign y_end = {1'b0, pos_y} + 11'(SPR_H*SCALE);
  assign hit   = ({1'b0, DrawX} >= {1'b0, pos_x}) && ({1'b0, DrawX} < x_end) &&
                 ({1'b0, DrawY} >= {1'b0, pos_y}) && ({1'b0, DrawY} < y_end);

  assign dx = DrawX - pos_x;
  assign dy = DrawY - pos_y;
  assign u  = UW'(dx / 10'(SCALE));
  assign v  = VW'(dy / 10'(SCALE));

`ifdef SPRITE_FLIP_EN
  assign u_eff = flip ? (UW'(SPR_W-1) - u) : u;
`else
  assign u_eff = u;
`endif

  assign addr_next = AW'(frame_idx) * AW'(SPR_W*SPR_H) + AW'(v) * AW'(SPR_W) + AW'(u_eff);

  assign at_origin   = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign frame_start = at_origin && !at_origin_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      at_origin_q <= 1'b0;
      tick        <= '0;
      frame_idx   <= '0;
    end else begin
      at_origin_q <= at_origin;
      if (anim_restart) begin
        tick      <= '0;
        frame_idx <= '0;
      end else if (frame_start && anim_en) begin
        if (tick == TW'(FRAME_TICKS-1)) begin
          tick      <= '0;
          frame_idx <= (frame_idx == FW'(FRAMES-1)) ? '0 : frame_idx + 1'b1;
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

  // vld flushes the pipe after reset so stale hit/ROM data never shows as opaque.
  assign opaque_next = vld[2] && hit_d2 && blank_d2 && (rom_q != 4'(KEY_INDEX));

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      hit_d1      <= 1'b0;
      blank_d1    <= 1'b0;
      hit_d2      <= 1'b0;
      blank_d2    <= 1'b0;
      vld         <= 3'b000;
      pix_opaque  <= 1'b0;
      pix_index   <= 4'd0;
    end else begin
      if (hit) rom_address <= addr_next;
      hit_d1     <= hit;
      blank_d1   <= blank;
      hit_d2     <= hit_d1;
      blank_d2   <= blank_d1;
      vld        <= {vld[1:0], 1'b1};
      pix_opaque <= opaque_next;
      pix_index  <= opaque_next ? rom_q : 4'd0;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// tb/tb_sprite_renderer.sv - directed self-checking bench for sprite_renderer
module tb_sprite_renderer;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank, anim_en, anim_restart;
  logic [13:0] rom_address;
  logic [3:0]  rom_q, pix_index;
  logic        pix_opaque;
  logic [1:0]  frame_idx;
  logic        key_mode;
`ifdef SPRITE_FLIP_EN
  logic        flip;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_renderer dut (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .blank(blank),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .anim_en(anim_en),
    .anim_restart(anim_restart),
`ifdef SPRITE_FLIP_EN
    .flip(flip),
`endif
    .rom_address(rom_address),
    .rom_q(rom_q),
    .pix_index(pix_index),
    .pix_opaque(pix_opaque),
    .frame_idx(frame_idx)
  );

  // Synchronous ROM: texel value is low address nibble with bit 0 forced, key_mode returns the key.
  always @(posedge vga_clk) rom_q <= key_mode ? 4'd0 : (rom_address[3:0] | 4'h1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic frame_pulse(input int n);
    repeat (n) begin
      DrawX = 10'd0; DrawY = 10'd0; step(1);
      DrawX = 10'd1; step(1);
    end
  endtask

  task automatic set_px(input int x, input int y);
    DrawX = 10'(x); DrawY = 10'(y);
  endtask

  initial begin
    reset_n = 1'b0; DrawX = 10'd5; DrawY = 10'd5; blank = 1'b0;
    pos_x = 10'd100; pos_y = 10'd50; anim_en = 1'b0; anim_restart = 1'b0;
    key_mode = 1'b0;
`ifdef SPRITE_FLIP_EN
    flip = 1'b0;
`endif
    step(3);
    chk("reset_rom_address", 32'(rom_address), 32'h0);
    chk("reset_pix_opaque", 32'(pix_opaque), 32'h0);
    chk("reset_pix_index", 32'(pix_index), 32'h0);
    chk("reset_frame_idx", 32'(frame_idx), 32'h0);
    reset_n = 1'b1;
    step(5);

    // top-left texel: address after 1 cycle, pixel after 3
    set_px(100, 50); blank = 1'b1;
    step(1); chk("tl_addr", 32'(rom_address), 32'h0);
    chk("tl_lat1_opaque", 32'(pix_opaque), 32'h0);
    step(1); chk("tl_lat2_opaque", 32'(pix_opaque), 32'h0);
    step(1); chk("tl_opaque", 32'(pix_opaque), 32'h1);
    chk("tl_index", 32'(pix_index), 32'h1);

    set_px(227, 177);
    step(1); chk("br_addr", 32'(rom_address), 32'd4095);
    step(2); chk("br_opaque", 32'(pix_opaque), 32'h1);
    chk("br_index", 32'(pix_index), 32'hf);

    set_px(228, 177);
    step(1); chk("right_clip_addr_hold", 32'(rom_address), 32'd4095);
    step(2); chk("right_clip_opaque", 32'(pix_opaque), 32'h0);
    chk("right_clip_index", 32'(pix_index), 32'h0);

    set_px(200, 178);
    step(3); chk("bottom_clip_opaque", 32'(pix_opaque), 32'h0);

    set_px(105, 53);
    step(1); chk("mid_addr", 32'(rom_address), 32'd66);
    step(2); chk("mid_index", 32'(pix_index), 32'h3);

`ifdef SPRITE_FLIP_EN
    flip = 1'b1; set_px(100, 50);
    step(1); chk("flip_addr", 32'(rom_address), 32'd63);
    step(2); chk("flip_index", 32'(pix_index), 32'hf);
    set_px(105, 53);
    step(1); chk("flip_mid_addr", 32'(rom_address), 32'd125);
    flip = 1'b0;
`endif

    key_mode = 1'b1; set_px(110, 60);
    step(3); chk("key_opaque", 32'(pix_opaque), 32'h0);
    chk("key_index", 32'(pix_index), 32'h0);
    key_mode = 1'b0; blank = 1'b0;
    step(3); chk("blank_opaque", 32'(pix_opaque), 32'h0);
    chk("blank_index", 32'(pix_index), 32'h0);
    blank = 1'b1;

    // right-edge clip, no wrap to column 0
    pos_x = 10'd600; set_px(639, 50);
    step(1); chk("edge_addr", 32'(rom_address), 32'd19);
    step(2); chk("edge_opaque", 32'(pix_opaque), 32'h1);
    set_px(600, 51);
    step(1); chk("edge_left_addr", 32'(rom_address), 32'd0);
    set_px(10, 50);
    step(1); chk("nowrap_addr_hold", 32'(rom_address), 32'd0);
    step(2); chk("nowrap_opaque", 32'(pix_opaque), 32'h0);
    pos_x = 10'd100;

    // animation
    anim_en = 1'b1;
    frame_pulse(7); chk("anim_7", 32'(frame_idx), 32'd0);
    frame_pulse(1); chk("anim_8", 32'(frame_idx), 32'd1);
    set_px(100, 50);
    step(1); chk("frame1_addr", 32'(rom_address), 32'h1000);
    frame_pulse(23); chk("anim_31", 32'(frame_idx), 32'd3);
    frame_pulse(1); chk("anim_32_wrap", 32'(frame_idx), 32'd0);
    anim_en = 1'b0;
    frame_pulse(10); chk("anim_hold", 32'(frame_idx), 32'd0);
    anim_en = 1'b1;
    frame_pulse(15); chk("anim_pre_restart", 32'(frame_idx), 32'd1);
    set_px(0, 0); anim_restart = 1'b1;
    step(1); chk("restart_coincident", 32'(frame_idx), 32'd0);
    anim_restart = 1'b0; DrawX = 10'd1;
    step(1);
    frame_pulse(7); chk("restart_tick_clr", 32'(frame_idx), 32'd0);
    frame_pulse(1); chk("restart_then_adv", 32'(frame_idx), 32'd1);
    set_px(5, 5); anim_restart = 1'b1;
    step(1); chk("restart_alone", 32'(frame_idx), 32'd0);
    anim_restart = 1'b0;

    // pipeline full, then asynchronous reset mid-cycle
    frame_pulse(8);
    set_px(227, 177);
    step(3); chk("pre_reset_opaque", 32'(pix_opaque), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_addr", 32'(rom_address), 32'h0);
    chk("async_rst_opaque", 32'(pix_opaque), 32'h0);
    chk("async_rst_index", 32'(pix_index), 32'h0);
    chk("async_rst_frame", 32'(frame_idx), 32'h0);
    step(1); reset_n = 1'b1;
    step(1); chk("post_rst_1", 32'(pix_opaque), 32'h0);
    step(1); chk("post_rst_2", 32'(pix_opaque), 32'h0);
    step(1); chk("post_rst_3", 32'(pix_opaque), 32'h0);
    step(1); chk("post_rst_4", 32'(pix_opaque), 32'h1);
    chk("post_rst_addr", 32'(rom_address), 32'd4095);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
